// File: rtl/tdm_demux8_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8_if
//  Purpose  : Serial input / published-frame bundle of the 8-slot TDM demux.
//  Revision : 1.0  initial release
// ============================================================================
interface tdm_demux8_if #(
    parameter int W = 1
);
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_sync;
    logic [8*W-1:0] dout;
    logic           frame_valid;
    logic [2:0]     slot;
    logic           locked;
    logic           sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, frame_valid, slot, locked, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8
//  Purpose  : 8-slot TDM receiver; assembles a frame in a shadow buffer and
//             publishes all eight channels at once, with framing recovery.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux8 #(
    parameter int W        = 1,
    parameter bit REQ_SYNC = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    tdm_demux8_if.slave  bus
);
    localparam logic [0:0] c_ST_HUNT   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;
    localparam int         c_NCH       = 8;

    logic [0:0]     r_state;
    logic [0:0]     w_state_next;
    logic [2:0]     r_slot;
    logic [W-1:0]   r_shadow [c_NCH];
    logic [8*W-1:0] r_dout;
    logic           r_frame_valid;
    logic           r_sync_err;

    logic           w_wr_en;
    logic [2:0]     w_wr_idx;
    logic [2:0]     w_slot_next;
    logic           w_publish;
    logic           w_err;
    logic           w_locked;
    logic [8*W-1:0] w_frame;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (bus.din_valid) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (bus.frame_sync) begin
                        w_state_next = c_ST_LOCKED;
                    end
                end
                c_ST_LOCKED: begin
                    if (!bus.frame_sync && (r_slot == 3'd0) && REQ_SYNC) begin
                        w_state_next = c_ST_HUNT;
                    end
                end
                default: w_state_next = c_ST_HUNT;
            endcase
        end
    end

    // ---------------- FSM: output / action decode ----------------
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = r_slot;
        w_slot_next = r_slot;
        w_publish   = 1'b0;
        w_err       = 1'b0;
        w_locked    = (r_state == c_ST_LOCKED);
        if (bus.din_valid) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (bus.frame_sync) begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = 3'd0;
                        w_slot_next = 3'd1;
                    end
                end
                c_ST_LOCKED: begin
                    if (bus.frame_sync && (r_slot != 3'd0)) begin
                        // Early sync: restart the frame on this word; stale
                        // shadow entries are overwritten before any publish.
                        w_err       = 1'b1;
                        w_wr_en     = 1'b1;
                        w_wr_idx    = 3'd0;
                        w_slot_next = 3'd1;
                    end else if (!bus.frame_sync && (r_slot == 3'd0) && REQ_SYNC) begin
                        w_err       = 1'b1;
                        w_slot_next = 3'd0;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = r_slot;
                        w_slot_next = r_slot + 3'd1;
                        w_publish   = (r_slot == 3'd7);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Shadow buffer and publish image ----------------
    for (genvar k = 0; k < c_NCH; k++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst) begin
                r_shadow[k] <= '0;
            end else if (w_wr_en && (w_wr_idx == 3'(k))) begin
                r_shadow[k] <= bus.din;
            end
        end

        if (k == c_NCH - 1) begin : g_last
            assign w_frame[k*W +: W] = bus.din;
        end else begin : g_prev
            assign w_frame[k*W +: W] = r_shadow[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot        <= 3'd0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_slot        <= w_slot_next;
            r_frame_valid <= w_publish;
            r_sync_err    <= w_err;
            if (w_publish) begin
                r_dout <= w_frame;
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.slot        = r_slot;
    assign bus.locked      = w_locked;
    assign bus.sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux8
//  Purpose  : Scoreboard bench for tdm_demux8 (REQ_SYNC=1 and REQ_SYNC=0 side
//             by side, same stimulus, reference model per instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux8;
    localparam int c_W = 4;

    typedef struct {
        bit          fv;
        bit          err;
        int          slot;
        bit          locked;
        logic [31:0] dout;
    } st_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tdm_demux8_if #(.W(c_W)) if_req  ();
    tdm_demux8_if #(.W(c_W)) if_nreq ();

    tdm_demux8 #(.W(c_W), .REQ_SYNC(1'b1)) u_req  (.clk(clk), .rst(rst), .bus(if_req.slave));
    tdm_demux8 #(.W(c_W), .REQ_SYNC(1'b0)) u_nreq (.clk(clk), .rst(rst), .bus(if_nreq.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = REQ_SYNC=1, index 1 = REQ_SYNC=0
    bit          m_locked [2];
    int          m_slot   [2];
    logic [3:0]  m_word   [2][8];
    logic [31:0] m_dout   [2];

    st_t         sq0 [$];
    st_t         sq1 [$];
    logic [31:0] fq0 [$];
    logic [31:0] fq1 [$];

    function automatic void model_step(int k, bit r, bit v, bit fs, logic [3:0] d);
        st_t s;
        bit  req = (k == 0);
        s.fv  = 1'b0;
        s.err = 1'b0;
        if (r) begin
            m_locked[k] = 1'b0;
            m_slot[k]   = 0;
            m_dout[k]   = '0;
            for (int i = 0; i < 8; i++) m_word[k][i] = '0;
        end else if (v) begin
            if (!m_locked[k]) begin
                if (fs) begin
                    m_word[k][0] = d;
                    m_slot[k]    = 1;
                    m_locked[k]  = 1'b1;
                end
            end else if (fs && m_slot[k] != 0) begin
                s.err        = 1'b1;
                m_word[k][0] = d;
                m_slot[k]    = 1;
            end else if (!fs && m_slot[k] == 0 && req) begin
                s.err       = 1'b1;
                m_locked[k] = 1'b0;
                m_slot[k]   = 0;
            end else begin
                m_word[k][m_slot[k]] = d;
                if (m_slot[k] == 7) begin
                    for (int i = 0; i < 8; i++) m_dout[k][i*4 +: 4] = m_word[k][i];
                    s.fv      = 1'b1;
                    m_slot[k] = 0;
                    if (k == 0) fq0.push_back(m_dout[k]);
                    else        fq1.push_back(m_dout[k]);
                end else begin
                    m_slot[k] = m_slot[k] + 1;
                end
            end
        end
        s.slot   = m_slot[k];
        s.locked = m_locked[k];
        s.dout   = m_dout[k];
        if (k == 0) sq0.push_back(s);
        else        sq1.push_back(s);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive at negedge, model the effect of the next posedge
    task automatic cycle(bit r, bit v, bit fs, logic [3:0] d);
        @(negedge clk);
        rst                = r;
        if_req.din_valid   = v;  if_nreq.din_valid  = v;
        if_req.frame_sync  = fs; if_nreq.frame_sync = fs;
        if_req.din         = d;  if_nreq.din        = d;
        model_step(0, r, v, fs, d);
        model_step(1, r, v, fs, d);
    endtask

    task automatic send_frame(bit gaps, logic [3:0] base);
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i % 2 == 1)) begin
                cycle(1'b0, 1'b0, 1'($urandom), 4'($urandom));
                cycle(1'b0, 1'b0, 1'($urandom), 4'($urandom));
            end
            cycle(1'b0, 1'b1, (i == 0), base + 4'(i));
        end
    endtask

    task automatic check_dut(int k);
        st_t         e;
        logic [31:0] f;
        logic        fv, err, lk;
        logic [2:0]  sl;
        logic [31:0] dq;
        string       tag = (k == 0) ? "req" : "nreq";
        fv  = (k == 0) ? if_req.frame_valid : if_nreq.frame_valid;
        err = (k == 0) ? if_req.sync_err    : if_nreq.sync_err;
        lk  = (k == 0) ? if_req.locked      : if_nreq.locked;
        sl  = (k == 0) ? if_req.slot        : if_nreq.slot;
        dq  = (k == 0) ? if_req.dout        : if_nreq.dout;
        if ((k == 0 && sq0.size() == 0) || (k == 1 && sq1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_status_queue actual=empty required=entry", tag);
            return;
        end
        e = (k == 0) ? sq0.pop_front() : sq1.pop_front();
        chk({tag, "_frame_valid"}, 32'(fv),  32'(e.fv));
        chk({tag, "_sync_err"},    32'(err), 32'(e.err));
        chk({tag, "_locked"},      32'(lk),  32'(e.locked));
        chk({tag, "_slot"},        32'(sl),  32'(e.slot[2:0]));
        chk({tag, "_dout"},        dq,       e.dout);
        if (fv === 1'b1) begin
            if ((k == 0 && fq0.size() == 0) || (k == 1 && fq1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s_frame actual=%0h required=no_frame", tag, dq);
            end else begin
                f = (k == 0) ? fq0.pop_front() : fq1.pop_front();
                chk({tag, "_frame"}, dq, f);
            end
        end
    endtask

    // Monitor: one status record per clock edge, frames popped on frame_valid
    initial begin
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            check_dut(0);
            check_dut(1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       fs;
        rst = 1'b1;
        if_req.din_valid  = 1'b0; if_nreq.din_valid  = 1'b0;
        if_req.frame_sync = 1'b0; if_nreq.frame_sync = 1'b0;
        if_req.din        = '0;   if_nreq.din        = '0;
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 1'b0; m_slot[k] = 0; m_dout[k] = '0;
            for (int i = 0; i < 8; i++) m_word[k][i] = '0;
        end

        // reset, then a clean frame with data 0..7 -> dout 0x76543210
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        send_frame(1'b0, 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0);

        // words before any sync after reset are dropped
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 4'hC);
        send_frame(1'b0, 4'hA);

        // frame with valid gaps
        send_frame(1'b1, 4'h0);

        // sync arriving at slot 3, then a full frame
        cycle(1'b0, 1'b1, 1'b1, 4'h9);
        cycle(1'b0, 1'b1, 1'b0, 4'h8);
        cycle(1'b0, 1'b1, 1'b0, 4'h7);
        send_frame(1'b0, 4'h3);

        // slot-0 word without sync
        cycle(1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'h5);
        send_frame(1'b0, 4'h1);

        // reset at slot 5, then two back-to-back frames
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, (i == 0), 4'(i + 2));
        cycle(1'b1, 1'b1, 1'b0, 4'hF);
        send_frame(1'b0, 4'h4);
        send_frame(1'b0, 4'h6);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (m_slot[0] == 0) fs = ($urandom_range(0, 7) != 0);
            else                fs = ($urandom_range(0, 19) == 0);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  fs, 4'($urandom));
        end

        @(posedge clk);
        #2;
        chk("status_queue_drained", 32'(sq0.size() + sq1.size()), 32'd0);
        chk("frame_queue_drained",  32'(fq0.size() + fq1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
